// File: rtl/vec_exu_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : vec_exu_pkg                                                      |
// | Brief    : Shared types and helpers for the vector execution unit.          |
// | Options  : VEC_EXU_SAT_EN (saturating add/sub legality, set by the top)     |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package vec_exu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_RSUB = 4'd2,
    OP_SLL  = 4'd3,
    OP_SRL  = 4'd4,
    OP_SRA  = 4'd5,
    OP_MULL = 4'd6,
    OP_MULH = 4'd7,
    OP_SADD = 4'd8,
    OP_SSUB = 4'd9
  } exu_op_e;

  typedef enum logic [1:0] {
    SEW_8   = 2'd0,
    SEW_16  = 2'd1,
    SEW_32  = 2'd2,
    SEW_ILL = 2'd3
  } sew_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } exu_state_e;

  function automatic int unsigned elem_count(input logic [1:0] sew, input int unsigned vlen);
    elem_count = vlen >> (32'd3 + 32'(sew));
  endfunction

  // Widen one element (held in the low bits) to 34 bits, sign- or zero-extended.
  function automatic logic [33:0] ext_elem(input logic [31:0] a, input logic [1:0] sew,
                                           input logic sgn);
    case (sew)
      2'd0:    ext_elem = sgn ? {{26{a[7]}}, a[7:0]}   : {26'd0, a[7:0]};
      2'd1:    ext_elem = sgn ? {{18{a[15]}}, a[15:0]} : {18'd0, a[15:0]};
      default: ext_elem = sgn ? {{2{a[31]}}, a}        : {2'd0, a};
    endcase
  endfunction

  function automatic logic op_is_mul(input logic [3:0] op);
    op_is_mul = (op == OP_MULL) || (op == OP_MULH);
  endfunction

  function automatic logic op_is_legal(input logic [3:0] op, input logic sat_en);
    op_is_legal = sat_en ? (op <= OP_SSUB) : (op <= OP_MULH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vec_exu_mul_chunk.sv
// +----------------------------------------------------------------------------+
// | Module   : vec_exu_mul_chunk                                                |
// | Brief    : Combinational element-wise multiplier over one CHUNK-bit slice.  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module vec_exu_mul_chunk
  import vec_exu_pkg::*;
#(
  parameter int CHUNK = 128
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [1:0]       sew,
  input  logic             signed_mode,
  input  logic             high,
  output logic [CHUNK-1:0] prod
);

  logic [31:0] w_p;

  // Both operands widened to 34 bits so one signed multiplier covers every mode.
  function automatic logic [31:0] f_mul(input logic [31:0] x, input logic [31:0] y,
                                        input logic [1:0] s, input logic sg, input logic hi);
    logic signed [33:0] ex;
    logic signed [33:0] ey;
    logic signed [67:0] p;
    ex = signed'(ext_elem(x, s, sg));
    ey = signed'(ext_elem(y, s, sg));
    p  = ex * ey;
    case (s)
      2'd0:    f_mul = hi ? {24'd0, p[15:8]}  : {24'd0, p[7:0]};
      2'd1:    f_mul = hi ? {16'd0, p[31:16]} : {16'd0, p[15:0]};
      default: f_mul = hi ? p[63:32] : p[31:0];
    endcase
  endfunction

  always_comb begin
    prod = '0;
    w_p  = '0;
    case (sew)
      2'd0: begin
        for (int i = 0; i < CHUNK/8; i++) begin
          w_p = f_mul({24'd0, a[i*8 +: 8]}, {24'd0, b[i*8 +: 8]}, sew, signed_mode, high);
          prod[i*8 +: 8] = w_p[7:0];
        end
      end
      2'd1: begin
        for (int i = 0; i < CHUNK/16; i++) begin
          w_p = f_mul({16'd0, a[i*16 +: 16]}, {16'd0, b[i*16 +: 16]}, sew, signed_mode, high);
          prod[i*16 +: 16] = w_p[15:0];
        end
      end
      default: begin
        for (int i = 0; i < CHUNK/32; i++) begin
          w_p = f_mul(a[i*32 +: 32], b[i*32 +: 32], sew, signed_mode, high);
          prod[i*32 +: 32] = w_p;
        end
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/vec_exec_unit_pipe.sv
// +----------------------------------------------------------------------------+
// | Module   : vec_exec_unit_pipe                                               |
// | Brief    : Handshaked vector ALU/multiply stage with vl tail zeroing.       |
// | Options  : VEC_EXU_SAT_EN enables saturating add/sub (ops 8/9).             |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module vec_exec_unit_pipe
  import vec_exu_pkg::*;
#(
  parameter int VLEN      = 512,
  parameter int MUL_CHUNK = 128,
  parameter int VL_W      = $clog2(VLEN/8) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [VLEN-1:0] data_1,
  input  logic [VLEN-1:0] data_2,
  input  logic [3:0]      op,
  input  logic [1:0]      sew,
  input  logic            signed_mode,
  input  logic [VL_W-1:0] vl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VLEN-1:0] result,
  output logic            err,
  output logic            busy
);

`ifdef VEC_EXU_SAT_EN
  localparam logic c_SAT_EN = 1'b1;
`else
  localparam logic c_SAT_EN = 1'b0;
`endif
  localparam int c_NCHUNK = VLEN / MUL_CHUNK;
  localparam int c_CNT_W  = $clog2(c_NCHUNK) + 1;

  exu_state_e           r_state;
  exu_state_e           w_state_nxt;
  logic [VLEN-1:0]      r_d1;
  logic [VLEN-1:0]      r_d2;
  logic [VLEN-1:0]      r_result;
  logic [3:0]           r_op;
  logic [1:0]           r_sew;
  logic                 r_sgn;
  logic [VL_W-1:0]      r_vl;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_err;
  logic                 w_accept;
  logic                 w_illegal;
  logic                 w_last;
  logic [VLEN-1:0]      w_alu;
  logic [VLEN-1:0]      w_mask;
  logic [31:0]          w_e;
  int unsigned          w_vl_eff;
  logic [MUL_CHUNK-1:0] w_mul_p;

  assign w_accept  = in_valid && in_ready;
  assign w_illegal = (r_sew == SEW_ILL) || !op_is_legal(r_op, c_SAT_EN);
  assign w_last    = (r_cnt == c_CNT_W'(c_NCHUNK - 1));
  assign result    = r_result;
  assign err       = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = (op_is_mul(op) && (sew != SEW_ILL)) ? MUL : EXEC;
      EXEC: w_state_nxt = DONE;
      MUL:  if (w_last) w_state_nxt = DONE;
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  function automatic logic [31:0] f_alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] o, input logic [1:0] s,
                                        input logic sg);
    logic [5:0]         w;
    logic [4:0]         sh;
    logic signed [33:0] ea;
    logic signed [33:0] eb;
    logic signed [33:0] sum;
    logic signed [33:0] lim_hi;
    logic signed [33:0] lim_lo;
    w     = 6'd8 << s;
    sh    = b[4:0] & 5'(w - 6'd1);
    f_alu = '0;
    case (o)
      OP_ADD:  f_alu = a + b;
      OP_SUB:  f_alu = a - b;
      OP_RSUB: f_alu = b - a;
      OP_SLL:  f_alu = a << sh;
      OP_SRL:  f_alu = a >> sh;
      OP_SRA: begin
        ea    = signed'(ext_elem(a, s, 1'b1));
        f_alu = 32'(ea >>> sh);
      end
      OP_SADD, OP_SSUB: begin
        if (c_SAT_EN) begin
          ea     = signed'(ext_elem(a, s, sg));
          eb     = signed'(ext_elem(b, s, sg));
          sum    = (o == OP_SADD) ? (ea + eb) : (ea - eb);
          lim_hi = sg ? ((34'sd1 <<< (w - 6'd1)) - 34'sd1) : ((34'sd1 <<< w) - 34'sd1);
          lim_lo = sg ? -(34'sd1 <<< (w - 6'd1)) : 34'sd0;
          if (sum > lim_hi)      f_alu = 32'(lim_hi);
          else if (sum < lim_lo) f_alu = 32'(lim_lo);
          else                   f_alu = 32'(sum);
        end
      end
      default: f_alu = '0;
    endcase
  endfunction

  always_comb begin
    w_alu = '0;
    w_e   = '0;
    case (r_sew)
      2'd0: begin
        for (int i = 0; i < VLEN/8; i++) begin
          w_e = f_alu({24'd0, r_d1[i*8 +: 8]}, {24'd0, r_d2[i*8 +: 8]}, r_op, r_sew, r_sgn);
          w_alu[i*8 +: 8] = w_e[7:0];
        end
      end
      2'd1: begin
        for (int i = 0; i < VLEN/16; i++) begin
          w_e = f_alu({16'd0, r_d1[i*16 +: 16]}, {16'd0, r_d2[i*16 +: 16]}, r_op, r_sew, r_sgn);
          w_alu[i*16 +: 16] = w_e[15:0];
        end
      end
      2'd2: begin
        for (int i = 0; i < VLEN/32; i++) begin
          w_e = f_alu(r_d1[i*32 +: 32], r_d2[i*32 +: 32], r_op, r_sew, r_sgn);
          w_alu[i*32 +: 32] = w_e;
        end
      end
      default: w_alu = '0;
    endcase
  end

  // Byte-granular tail mask: byte b belongs to element b >> sew.
  always_comb begin
    w_mask   = '0;
    w_vl_eff = 32'(r_vl);
    if (w_vl_eff > elem_count(r_sew, VLEN)) w_vl_eff = elem_count(r_sew, VLEN);
    for (int b = 0; b < VLEN/8; b++) begin
      if ((32'(b) >> r_sew) < w_vl_eff) w_mask[b*8 +: 8] = 8'hFF;
    end
  end

  vec_exu_mul_chunk #(
    .CHUNK (MUL_CHUNK)
  ) u_mul (
    .a           (r_d1[int'(r_cnt)*MUL_CHUNK +: MUL_CHUNK]),
    .b           (r_d2[int'(r_cnt)*MUL_CHUNK +: MUL_CHUNK]),
    .sew         (r_sew),
    .signed_mode (r_sgn),
    .high        (r_op == OP_MULH),
    .prod        (w_mul_p)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d1     <= '0;
      r_d2     <= '0;
      r_op     <= '0;
      r_sew    <= '0;
      r_sgn    <= 1'b0;
      r_vl     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_d1  <= data_1;
            r_d2  <= data_2;
            r_op  <= op;
            r_sew <= sew;
            r_sgn <= signed_mode;
            r_vl  <= vl;
            r_cnt <= '0;
            r_err <= 1'b0;
          end
        end
        EXEC: begin
          r_result <= w_illegal ? '0 : (w_alu & w_mask);
          r_err    <= w_illegal;
        end
        MUL: begin
          r_result[int'(r_cnt)*MUL_CHUNK +: MUL_CHUNK] <=
            w_mul_p & w_mask[int'(r_cnt)*MUL_CHUNK +: MUL_CHUNK];
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vec_exec_unit_pipe.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_vec_exec_unit_pipe                                            |
// | Brief    : Directed self-checking bench for vec_exec_unit_pipe.             |
// | Options  : VEC_EXU_SAT_EN selects the saturating expectations.              |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vec_exec_unit_pipe;

  localparam int VLEN      = 512;
  localparam int MUL_CHUNK = 128;
  localparam int VL_W      = $clog2(VLEN/8) + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [VLEN-1:0] data_1;
  logic [VLEN-1:0] data_2;
  logic [3:0]      op;
  logic [1:0]      sew;
  logic            signed_mode;
  logic [VL_W-1:0] vl;
  logic            out_valid;
  logic            out_ready;
  logic [VLEN-1:0] result;
  logic            err;
  logic            busy;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_exec_unit_pipe #(
    .VLEN      (VLEN),
    .MUL_CHUNK (MUL_CHUNK),
    .VL_W      (VL_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_1      (data_1),
    .data_2      (data_2),
    .op          (op),
    .sew         (sew),
    .signed_mode (signed_mode),
    .vl          (vl),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .err         (err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VLEN-1:0] splat(input logic [31:0] v, input int w);
    logic [VLEN-1:0] r;
    logic [VLEN-1:0] m;
    r = '0;
    m = (VLEN'(1) << w) - VLEN'(1);
    for (int i = 0; i < VLEN/w; i++) r = r | ((VLEN'(v) & m) << (i*w));
    return r;
  endfunction

  // Called with the bench sitting 1 time unit after a rising edge and the DUT idle.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [1:0] s,
                        input logic sg, input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                        input int v, input logic [VLEN-1:0] er, input logic ee,
                        input int elat, input int hold);
    int lat;
    data_1      = a;
    data_2      = b;
    op          = o;
    sew         = s;
    signed_mode = sg;
    vl          = VL_W'(v);
    in_valid    = 1'b1;
    check({tag, ".in_ready_idle"}, VLEN'(in_ready), VLEN'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      check({tag, ".in_ready_busy"}, VLEN'(in_ready), VLEN'(0));
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, VLEN'(lat), VLEN'(elat));
    check({tag, ".result"}, result, er);
    check({tag, ".err"}, VLEN'(err), VLEN'(ee));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, VLEN'(out_valid), VLEN'(1));
      check({tag, ".hold_result"}, result, er);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".released"}, VLEN'(out_valid), VLEN'(0));
  endtask

  initial begin
    logic [VLEN-1:0] exp_v;
    reset       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    data_1      = '0;
    data_2      = '0;
    op          = '0;
    sew         = '0;
    signed_mode = 1'b0;
    vl          = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.out_valid", VLEN'(out_valid), VLEN'(0));
    check("rst.result", result, '0);
    check("rst.err", VLEN'(err), VLEN'(0));
    check("rst.busy", VLEN'(busy), VLEN'(0));
    check("rst.in_ready", VLEN'(in_ready), VLEN'(1));
    #3 reset = 1'b1;
    @(posedge clk); #1;

    run_op("add8_wrap", 4'd0, 2'd0, 1'b0, splat(32'hFF, 8), splat(32'h01, 8), 64,
           '0, 1'b0, 2, 0);

    exp_v = '0;
    for (int w = 0; w < 4; w++) exp_v[w*32 +: 32] = 32'hFFFF_FFFE;
    run_op("rsub32_vl4", 4'd2, 2'd2, 1'b0, splat(32'd5, 32), splat(32'd3, 32), 4,
           exp_v, 1'b0, 2, 0);

    run_op("mulh16_signed", 4'd7, 2'd1, 1'b1, splat(32'h8000, 16), splat(32'h8000, 16), 32,
           splat(32'h4000, 16), 1'b0, 5, 0);

    run_op("sra32_hold", 4'd5, 2'd2, 1'b0, splat(32'h8000_0000, 32), splat(32'd33, 32), 16,
           splat(32'hC000_0000, 32), 1'b0, 2, 3);

    run_op("mull8_unsigned", 4'd6, 2'd0, 1'b0, splat(32'h10, 8), splat(32'h11, 8), 64,
           splat(32'h10, 8), 1'b0, 5, 0);

    run_op("mulh32_unsigned", 4'd7, 2'd2, 1'b0, splat(32'hFFFF_FFFF, 32),
           splat(32'hFFFF_FFFF, 32), 16, splat(32'hFFFF_FFFE, 32), 1'b0, 5, 0);

    run_op("sub16_wrap", 4'd1, 2'd1, 1'b0, '0, splat(32'h0001, 16), 32,
           splat(32'hFFFF, 16), 1'b0, 2, 0);

    run_op("sll8_amt3", 4'd3, 2'd0, 1'b0, splat(32'h01, 8), splat(32'h0B, 8), 64,
           splat(32'h08, 8), 1'b0, 2, 0);

    run_op("srl16_amt4", 4'd4, 2'd1, 1'b0, splat(32'h8000, 16), splat(32'h0014, 16), 32,
           splat(32'h0800, 16), 1'b0, 2, 0);

    run_op("add32_vl_clamp", 4'd0, 2'd2, 1'b0, splat(32'd1, 32), splat(32'd2, 32), 40,
           splat(32'd3, 32), 1'b0, 2, 0);

    run_op("add8_vl0", 4'd0, 2'd0, 1'b0, splat(32'h11, 8), splat(32'h22, 8), 0,
           '0, 1'b0, 2, 0);

    run_op("illegal_sew", 4'd0, 2'd3, 1'b0, splat(32'h11, 8), splat(32'h22, 8), 64,
           '0, 1'b1, 2, 0);

    run_op("illegal_op", 4'd12, 2'd0, 1'b0, splat(32'h11, 8), splat(32'h22, 8), 64,
           '0, 1'b1, 2, 0);

`ifdef VEC_EXU_SAT_EN
    run_op("sadd8_sat", 4'd8, 2'd0, 1'b1, splat(32'h7F, 8), splat(32'h01, 8), 64,
           splat(32'h7F, 8), 1'b0, 2, 0);
    run_op("ssub8_unsigned_sat", 4'd9, 2'd0, 1'b0, splat(32'h00, 8), splat(32'h01, 8), 64,
           '0, 1'b0, 2, 0);
`else
    run_op("sadd8_disabled", 4'd8, 2'd0, 1'b1, splat(32'h7F, 8), splat(32'h01, 8), 64,
           '0, 1'b1, 2, 0);
`endif

    // Abort a multiply while the third chunk is in flight.
    data_1      = splat(32'h03, 8);
    data_2      = splat(32'h03, 8);
    op          = 4'd6;
    sew         = 2'd0;
    signed_mode = 1'b0;
    vl          = VL_W'(64);
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort.busy_before", VLEN'(busy), VLEN'(1));
    reset = 1'b0;
    #1;
    check("abort.out_valid", VLEN'(out_valid), VLEN'(0));
    check("abort.result", result, '0);
    check("abort.busy", VLEN'(busy), VLEN'(0));
    check("abort.in_ready", VLEN'(in_ready), VLEN'(1));
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check("abort.idle_after", VLEN'(in_ready), VLEN'(1));
    check("abort.no_output", VLEN'(out_valid), VLEN'(0));

    run_op("add8_after_abort", 4'd0, 2'd0, 1'b0, splat(32'h05, 8), splat(32'h06, 8), 64,
           splat(32'h0B, 8), 1'b0, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
